// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch unit.
package fetch_pkg;

  localparam int unsigned FETCH_ADDR_W   = 16;
  localparam int unsigned FETCH_INSTR_W  = 32;
  localparam logic [15:0] FETCH_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [FETCH_ADDR_W-1:0]  pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; flush wins over push.
module fetch_queue #(
  parameter int unsigned WIDTH = 48,
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [WIDTH-1:0]           head_data,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];
  assign do_pop    = pop && (count_q != '0);
  assign do_push   = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch sequencer: PC register, run/halt FSM and the queue feeding decode.
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = FETCH_ADDR_W,
  parameter int unsigned       INSTR_W  = FETCH_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(FETCH_RESET_PC),
  parameter int unsigned       DEPTH    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_instr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  output logic               running,
  output logic [15:0]        fetch_count
);

  fetch_state_e               state_q, state_d;
  logic [ADDR_W-1:0]          pc_q, pc_d;
  logic [15:0]                fetch_count_q, fetch_count_d;
  logic                       running_q, running_d;
  logic [$clog2(DEPTH+1)-1:0] q_count;
  logic                       q_full;
  logic                       push, pop;

  assign imem_addr   = pc_q;
  assign running     = running_q;
  assign fetch_count = fetch_count_q;
  assign out_valid   = (q_count != '0);
  assign pop         = out_valid && out_ready;
  // A redirect discards the whole queue, so an accepted head needs no separate pop.
  assign push        = (state_q == ST_RUN) && !redirect_valid && !halt && (!q_full || pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (!halt && start) state_d = ST_RUN;
      ST_RUN:    if (halt) state_d = ST_HALTED;
      ST_HALTED: if (!halt && start) state_d = ST_RUN;
      default:   state_d = ST_IDLE;
    endcase
    running_d = (state_d == ST_RUN);

    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    if (redirect_valid) begin
      pc_d = redirect_pc;
    end else if (push) begin
      pc_d          = pc_q + ADDR_W'(1);
      fetch_count_d = fetch_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      running_q     <= 1'b0;
      pc_q          <= RESET_PC;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      running_q     <= running_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  fetch_queue #(
    .WIDTH (ADDR_W + INSTR_W),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data ({pc_q, imem_instr}),
    .pop       (pop),
    .flush     (redirect_valid),
    .head_data ({out_pc, out_instr}),
    .count     (q_count),
    .full      (q_full)
  );

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit; memory word k holds 32'h1000_0000 + k.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, halt, redirect_valid, out_ready;
  logic [15:0] redirect_pc;
  logic [15:0] imem_addr;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic [31:0] out_instr;
  logic [15:0] out_pc;
  logic        running;
  logic [15:0] fetch_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign imem_instr = 32'h1000_0000 + {16'h0000, imem_addr};

  instr_fetch_unit #(
    .ADDR_W   (16),
    .INSTR_W  (32),
    .RESET_PC (16'h0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .halt           (halt),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_addr      (imem_addr),
    .imem_instr     (imem_instr),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .running        (running),
    .fetch_count    (fetch_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; halt = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 16'h0000; out_ready = 1'b0;
    #2;
    chk("rst_addr", 64'(imem_addr), 64'h0);
    chk("rst_valid", 64'(out_valid), 64'h0);
    chk("rst_instr", 64'(out_instr), 64'h0);
    chk("rst_pc", 64'(out_pc), 64'h0);
    chk("rst_running", 64'(running), 64'h0);
    chk("rst_count", 64'(fetch_count), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // cycle 0: start
    start = 1'b1; out_ready = 1'b1;
    step();
    chk("c1_running", 64'(running), 64'h1);
    chk("c1_valid", 64'(out_valid), 64'h0);
    start = 1'b0;
    step();
    chk("c2_valid", 64'(out_valid), 64'h1);
    chk("c2_pc", 64'(out_pc), 64'h0);
    chk("c2_instr", 64'(out_instr), 64'h1000_0000);
    chk("c2_count", 64'(fetch_count), 64'h1);
    for (int k = 1; k <= 3; k++) begin
      step();
      chk("stream_pc", 64'(out_pc), 64'(k));
      chk("stream_instr", 64'(out_instr), 64'h1000_0000 + 64'(k));
    end
    chk("c5_count", 64'(fetch_count), 64'h4);

    // backpressure for 5 cycles (cycles 5..9)
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("bp_addr", 64'(imem_addr), 64'h5);
      chk("bp_head", 64'(out_pc), 64'h3);
      chk("bp_count", 64'(fetch_count), 64'h5);
    end
    step();
    out_ready = 1'b1;
    chk("rel_head0", 64'(out_pc), 64'h3);
    step();
    chk("rel_head1", 64'(out_pc), 64'h4);
    step();
    chk("rel_head2", 64'(out_pc), 64'h5);
    chk("rel_addr", 64'(imem_addr), 64'h7);
    chk("rel_count", 64'(fetch_count), 64'h7);

    // redirect with full queue
    out_ready = 1'b0;
    redirect_valid = 1'b1; redirect_pc = 16'h0040;
    step();
    redirect_valid = 1'b0; out_ready = 1'b1;
    chk("rd_valid", 64'(out_valid), 64'h0);
    chk("rd_addr", 64'(imem_addr), 64'h40);
    chk("rd_count", 64'(fetch_count), 64'h7);
    step();
    chk("rd_head0", 64'(out_pc), 64'h40);
    chk("rd_instr0", 64'(out_instr), 64'h1000_0040);
    step();
    chk("rd_head1", 64'(out_pc), 64'h41);
    chk("rd_count2", 64'(fetch_count), 64'h9);

    // redirect near the top of the address space
    redirect_valid = 1'b1; redirect_pc = 16'hFFFE;
    step();
    redirect_valid = 1'b0;
    chk("wr_valid", 64'(out_valid), 64'h0);
    chk("wr_addr", 64'(imem_addr), 64'hFFFE);
    step();
    chk("wr_pc0", 64'(out_pc), 64'hFFFE);
    chk("wr_instr0", 64'(out_instr), 64'h1000_FFFE);
    step();
    chk("wr_pc1", 64'(out_pc), 64'hFFFF);
    step();
    chk("wr_pc2", 64'(out_pc), 64'h0000);
    step();
    chk("wr_pc3", 64'(out_pc), 64'h0001);
    chk("wr_count", 64'(fetch_count), 64'd13);

    // halt with two queued entries
    out_ready = 1'b0;
    step();
    chk("h_full_head", 64'(out_pc), 64'h0001);
    chk("h_full_addr", 64'(imem_addr), 64'h0003);
    halt = 1'b1; out_ready = 1'b1;
    step();
    halt = 1'b0;
    chk("h_running", 64'(running), 64'h0);
    chk("h_head", 64'(out_pc), 64'h0002);
    chk("h_count", 64'(fetch_count), 64'd14);
    step();
    chk("h_drained", 64'(out_valid), 64'h0);
    step();
    chk("h_idle_valid", 64'(out_valid), 64'h0);
    chk("h_idle_addr", 64'(imem_addr), 64'h0003);
    chk("h_idle_count", 64'(fetch_count), 64'd14);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("res_running", 64'(running), 64'h1);
    step();
    chk("res_head", 64'(out_pc), 64'h0003);
    chk("res_valid", 64'(out_valid), 64'h1);
    chk("res_count", 64'(fetch_count), 64'd15);

    // asynchronous reset mid-stream
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_valid", 64'(out_valid), 64'h0);
    chk("ar_running", 64'(running), 64'h0);
    chk("ar_count", 64'(fetch_count), 64'h0);
    chk("ar_addr", 64'(imem_addr), 64'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    step();
    chk("post_running", 64'(running), 64'h0);
    chk("post_valid", 64'(out_valid), 64'h0);
    chk("post_addr", 64'(imem_addr), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Instruction fetch sequencer for the single-cycle-read instruction memory (16-bit word address, 32-bit instruction). Owns the program counter, drives the memory address, and buffers fetched words with their PCs in a small queue feeding decode over a valid/ready handshake. Handles start, halt and branch/jump redirect with queue flush; sits between the instruction memory and the decode stage.

## Interface
- ADDR_W, 16, PC / memory word-address width
- INSTR_W, 32, instruction width
- RESET_PC, 16'h0000, PC value after reset
- DEPTH, 2, fetch queue entries (power of two, ≥2)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin/resume fetching (level, sampled each cycle)
- halt  in  1  stop fetching; queued entries still drain
- redirect_valid  in  1  branch/jump taken; flush and reload PC
- redirect_pc  in  ADDR_W  new PC target
- imem_addr  out  ADDR_W  address to instruction memory (= PC register)
- imem_instr  in  INSTR_W  instruction from memory, combinational same-cycle
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_instr  out  INSTR_W  head instruction
- out_pc  out  ADDR_W  head PC
- running  out  1  state == RUN
- fetch_count  out  16  enqueued-instruction counter, wraps

## Operation
- States: IDLE, RUN, HALTED. Reset → IDLE, pc=RESET_PC, queue empty, fetch_count=0.
- IDLE: start → RUN. HALTED: start (no halt) → RUN. RUN: halt → HALTED.
- Priority per cycle: redirect_valid > halt > start.
- Redirect, any state: pc←redirect_pc, queue flushed (out_valid low next cycle), no enqueue that cycle; state transitions per halt/start still apply.
- Enqueue condition: state==RUN, no redirect, no halt, and (count<DEPTH or pop this cycle). Enqueue pushes {pc, imem_instr}; pc←pc+1 modulo 2^ADDR_W (0xFFFF→0x0000); fetch_count+1.
- Pop: out_valid && out_ready. Simultaneous push/pop when full allowed; count unchanged.
- Redirect plus out_ready same cycle: head counts as accepted; all others discarded.
- HALTED/IDLE: no enqueue; decode may keep draining.
- out_instr/out_pc undefined-content-don't-care when out_valid=0, but must be deterministic (hold last head or zero).

## Timing
- Reset values: imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0, running=0, fetch_count=0.
- imem_addr combinational from pc register; memory read and enqueue in same cycle.
- Start asserted cycle 0 → running=1 cycle 1 → first entry enqueued end of cycle 1 → out_valid=1 cycle 2 (out_pc=RESET_PC).
- Redirect in cycle n → out_valid=0 cycle n+1, imem_addr=redirect_pc cycle n+1, target visible at head cycle n+2.
- Throughput: one instruction per cycle with out_ready held high.
- rst_n low mid-operation: all state cleared immediately (asynchronous); fetching resumes only after new start.

## Structure
- Package fetch_pkg: state enum (IDLE, RUN, HALTED), fetch-entry struct {pc, instr}, RESET_PC default constant.
- Sub-module fetch_queue: synchronous FIFO of fetch entries, DEPTH parameter, push/pop/flush, count, full/empty; flush has priority over push.
- Top holds FSM, PC register, counter, enqueue logic.

## Test plan
- Reset, start pulse, out_ready=1, memory word k = 32'h1000_0000+k → out_pc 0,1,2,3 on consecutive cycles from cycle 2; fetch_count=4 after 4 pushes.
- out_ready=0 for 5 cycles while RUN → queue fills to DEPTH, imem_addr stops at RESET_PC+DEPTH, no entry lost or duplicated on release.
- Redirect to 16'h0040 while queue full → next cycle out_valid=0, then out_pc=0x0040, 0x0041; stale entries never appear.
- Redirect_pc=16'hFFFE, run 4 pushes → out_pc FFFE, FFFF, 0000, 0001.
- Halt during RUN with 2 queued → no new pushes, 2 entries drain, state HALTED; start → resumes at next sequential PC.
- rst_n asserted mid-stream with out_valid=1 → out_valid, running, fetch_count drop to 0 without clock edge; imem_addr=RESET_PC.
